// File: rtl/matmul_pkg.sv
// Shared definitions for the 3x3 matrix-multiply sequencer: dimensions, MAC latency,
// controller state encoding and the row-major flat-index helper.
package matmul_pkg;

  localparam int N       = 3;
  localparam int IDX_W   = 4;
  localparam int MAC_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int idx(input int r, input int c);
    return r * N + c;
  endfunction

endpackage

// File: rtl/wb_delay_line.sv
// Writeback delay line: carries {valid, C index} from the issue of a row/column's final
// product to the cycle its accumulated result is ready to be written to C.
module wb_delay_line
  import matmul_pkg::*;
#(
  parameter int W     = IDX_W,
  parameter int DEPTH = MAC_LAT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_idx,
  output logic         out_valid,
  output logic [W-1:0] out_idx
);

  typedef struct packed {
    logic         valid;
    logic [W-1:0] widx;
  } entry_t;

  entry_t line_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every stage is reset, not just the valid bits, so the index output is 0 out of reset.
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) line_q[s] <= '0;
    end else if (flush) begin
      for (int s = 0; s < DEPTH; s++) line_q[s] <= '0;
    end else begin
      // Idle slots carry index 0 so c_wr_idx reads 0 whenever c_wr_en is low.
      line_q[0].valid <= in_valid;
      line_q[0].widx  <= in_valid ? in_idx : '0;
      for (int s = 1; s < DEPTH; s++) line_q[s] <= line_q[s-1];
    end
  end

  assign out_valid = line_q[DEPTH-1].valid;
  assign out_idx   = line_q[DEPTH-1].widx;

endmodule

// File: rtl/matmul_sequencer.sv
// Issue-order controller for the shared-MAC 3x3 multiply: walks (i, j, k) in row-major order,
// drives operand indices and accumulator controls, and schedules C writebacks.
module matmul_sequencer
  import matmul_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             mac_en,
  output logic             mac_clr,
  output logic             mac_last,
  output logic [IDX_W-1:0] a_idx,
  output logic [IDX_W-1:0] b_idx,
  output logic             c_wr_en,
  output logic [IDX_W-1:0] c_wr_idx
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int DRN_W = $clog2(MAC_LAT + 1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(N - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(MAC_LAT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] i_q, j_q, k_q;
  logic [DRN_W-1:0] drn_q;
  logic             issue;
  logic             final_term;
  logic [IDX_W-1:0] wb_idx;

  assign issue      = (state == ISSUE) && !stall;
  assign final_term = (i_q == LAST) && (j_q == LAST) && (k_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers take <= so every flop samples the values from before the edge.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: next state defaults to the current one first, so no path leaves it unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (issue && final_term) state_nxt = DRAIN;
      DRAIN:   if (drn_q == DRN_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // k is innermost, then j, then i; all three are back at 0 after the final product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (abort) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (issue) begin
      if (k_q == LAST) begin
        k_q <= '0;
        if (j_q == LAST) begin
          j_q <= '0;
          i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end else begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  // DRAIN lasts MAC_LAT cycles, long enough for the final writeback to leave the delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     drn_q <= '0;
    else if (state == DRAIN && state_nxt == DRAIN)  drn_q <= drn_q + 1'b1;
    else                                            drn_q <= '0;
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign mac_en   = issue;
  assign mac_clr  = issue && (k_q == '0);
  assign mac_last = issue && (k_q == LAST);
  assign a_idx    = (state == ISSUE) ? IDX_W'(idx(int'(i_q), int'(k_q))) : '0;
  assign b_idx    = (state == ISSUE) ? IDX_W'(idx(int'(k_q), int'(j_q))) : '0;
  assign wb_idx   = IDX_W'(idx(int'(i_q), int'(j_q)));

  wb_delay_line #(
    .W     (IDX_W),
    .DEPTH (MAC_LAT)
  ) u_wb_delay_line (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .in_valid  (mac_last),
    .in_idx    (wb_idx),
    .out_valid (c_wr_en),
    .out_idx   (c_wr_idx)
  );

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: a reference issue/writeback order and a MAC model
// fed from the DUT's operand indices, with random A/B and random stalls.
module tb_matmul_sequencer;
  import matmul_pkg::*;

  localparam int NN = N * N;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             stall = 1'b0;
  logic             busy, done, mac_en, mac_clr, mac_last, c_wr_en;
  logic [IDX_W-1:0] a_idx, b_idx, c_wr_idx;

  matmul_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .mac_en   (mac_en),
    .mac_clr  (mac_clr),
    .mac_last (mac_last),
    .a_idx    (a_idx),
    .b_idx    (b_idx),
    .c_wr_en  (c_wr_en),
    .c_wr_idx (c_wr_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int clr;
    int last;
  } iss_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  iss_t exp_iss[$];
  int   exp_wb[$];
  int   pend[$];
  int   iss_rel[$];
  int   wb_rel[$];
  int   done_rel[$];
  int   A[NN];
  int   B[NN];
  int   C[NN];
  int   acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qat(input int q[$], input int n);
    return (n >= 0 && n < q.size()) ? q[n] : -1;
  endfunction

  // Monitor: every presented product or writeback is matched against the expected order.
  always @(negedge clk) begin
    iss_t e;
    int   prod;
    if (mac_en) begin
      iss_rel.push_back(cyc - t0);
      if (exp_iss.size() == 0) begin
        check("unexpected_issue", 1, 0);
      end else begin
        e = exp_iss.pop_front();
        check("a_idx", a_idx, e.a);
        check("b_idx", b_idx, e.b);
        check("mac_clr", mac_clr, e.clr);
        check("mac_last", mac_last, e.last);
      end
      prod = (a_idx < NN && b_idx < NN) ? A[a_idx] * B[b_idx] : 0;
      acc  = mac_clr ? prod : acc + prod;
      if (mac_last) pend.push_back(acc);
    end else if (mac_clr || mac_last) begin
      check("ctrl_without_mac_en", 1, 0);
    end
    if (c_wr_en) begin
      wb_rel.push_back(cyc - t0);
      if (exp_wb.size() == 0) check("unexpected_wb", 1, 0);
      else                    check("c_wr_idx", c_wr_idx, exp_wb.pop_front());
      if (pend.size() > 0 && c_wr_idx < NN) C[c_wr_idx] = pend.pop_front();
    end else begin
      check("c_wr_idx_idle", c_wr_idx, 0);
    end
    if (done) done_rel.push_back(cyc - t0);
  end

  task automatic clear_sb();
    exp_iss.delete();
    exp_wb.delete();
    pend.delete();
    iss_rel.delete();
    wb_rel.delete();
    done_rel.delete();
  endtask

  // Reference order: C[i][j] = sum_k A[i][k]*B[k][j], row-major results, k innermost.
  task automatic expect_run();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        for (int k = 0; k < N; k++)
          exp_iss.push_back('{a: i*N + k, b: k*N + j, clr: int'(k == 0), last: int'(k == N-1)});
        exp_wb.push_back(i*N + j);
      end
  endtask

  task automatic randomize_ab();
    for (int x = 0; x < NN; x++) begin
      A[x] = int'($urandom_range(0, 255));
      B[x] = int'($urandom_range(0, 255));
      C[x] = -1;
    end
  endtask

  task automatic check_product(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int sum = 0;
        for (int k = 0; k < N; k++) sum += A[i*N + k] * B[k*N + j];
        check($sformatf("%s_c[%0d][%0d]", tag, i, j), C[i*N + j], sum);
      end
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_iss_left"}, exp_iss.size(), 0);
    check({tag, "_wb_left"}, exp_wb.size(), 0);
  endtask

  // One-cycle start pulse; t0 becomes the first ISSUE cycle.
  task automatic kick();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int n_done, input int budget, input string tag);
    int c = 0;
    while (done_rel.size() < n_done && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    if (done_rel.size() < n_done) check({tag, "_done_timeout"}, done_rel.size(), n_done);
  endtask

  initial begin
    int nst;

    #1 rst_n = 1'b0;
    #3 check("reset_outputs",
             {busy, done, mac_en, mac_clr, mac_last, c_wr_en, a_idx, b_idx, c_wr_idx}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: plain run, full timing
    clear_sb(); randomize_ab(); expect_run(); kick();
    wait_done(1, 100, "t1");
    check("t1_done_cycle", qat(done_rel, 0), N*N*N + MAC_LAT);
    @(negedge clk); #1;
    check("t1_busy_after", busy, 0);
    check("t1_done_pulse", done_rel.size(), 1);
    check("t1_issue_count", iss_rel.size(), N*N*N);
    check("t1_first_issue", qat(iss_rel, 0), 0);
    check("t1_last_issue", qat(iss_rel, N*N*N - 1), N*N*N - 1);
    check("t1_wb_count", wb_rel.size(), NN);
    for (int m = 0; m < NN; m++)
      check($sformatf("t1_wb_cycle[%0d]", m), qat(wb_rel, m), N*m + N - 1 + MAC_LAT);
    check_drained("t1");
    check_product("t1");

    // 2: three stall cycles after ten issues
    clear_sb(); randomize_ab(); expect_run(); kick();
    repeat (10) @(posedge clk);
    #1 check("t2_issued_before_stall", iss_rel.size(), 10);
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); #1;
      check("t2_stall_mac_en", {mac_en, mac_clr, mac_last}, 0);
      check("t2_stall_a_idx", a_idx, exp_iss[0].a);
      check("t2_stall_b_idx", b_idx, exp_iss[0].b);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    wait_done(1, 100, "t2");
    check("t2_done_cycle", qat(done_rel, 0), N*N*N + MAC_LAT + 3);
    check_drained("t2");
    check_product("t2");

    // 3: abort mid-ISSUE, then abort+start together in IDLE
    clear_sb(); randomize_ab(); expect_run(); kick();
    repeat (15) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("t3_busy_after_abort", busy, 0);
    check("t3_issues_before_abort", iss_rel.size(), 16);
    check("t3_wb_before_abort", wb_rel.size(), 4);
    clear_sb();
    repeat (40) @(posedge clk);
    #1;
    check("t3_no_issue_after", iss_rel.size(), 0);
    check("t3_no_wb_after", wb_rel.size(), 0);
    check("t3_no_done", done_rel.size(), 0);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    check("t3_abort_beats_start", busy, 0);

    // 4: start held high -> two back-to-back runs
    clear_sb(); randomize_ab(); expect_run(); expect_run();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 t0 = cyc;
    for (int c = 0; c < 100 && iss_rel.size() <= N*N*N; c++) @(negedge clk);
    @(posedge clk); #1 start = 1'b0;
    wait_done(2, 100, "t4");
    check("t4_first_done", qat(done_rel, 0), N*N*N + MAC_LAT);
    check("t4_second_issue_start", qat(iss_rel, N*N*N), N*N*N + MAC_LAT + 2);
    check("t4_second_done", qat(done_rel, 1), 2*(N*N*N + MAC_LAT) + 2);
    @(negedge clk); #1;
    check("t4_idle_after", busy, 0);
    check_drained("t4");
    check_product("t4");

    // 5: reset during DRAIN, then a fresh full run
    clear_sb(); randomize_ab(); expect_run(); kick();
    repeat (N*N*N) @(posedge clk);
    #1 check("t5_in_drain", {busy, mac_en}, 2'b10);
    #1 rst_n = 1'b0;
    #1 check("t5_reset_outputs",
             {busy, done, mac_en, mac_clr, mac_last, c_wr_en, a_idx, b_idx, c_wr_idx}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    clear_sb(); randomize_ab(); expect_run(); kick();
    wait_done(1, 100, "t5");
    check("t5_done_cycle", qat(done_rel, 0), N*N*N + MAC_LAT);
    check_drained("t5");
    check_product("t5");

    // 6: random stalls during ISSUE over several runs
    for (int r = 0; r < 4; r++) begin
      clear_sb(); randomize_ab(); expect_run(); kick();
      nst = 0;
      for (int c = 0; c < 300 && iss_rel.size() < N*N*N; c++) begin
        stall = ($urandom_range(0, 3) == 0);
        if (stall) nst++;
        @(posedge clk); #1;
      end
      stall = 1'b0;
      wait_done(1, 100, "t6");
      check($sformatf("t6_done_cycle_run%0d", r), qat(done_rel, 0), N*N*N + MAC_LAT + nst);
      check_drained("t6");
      check_product($sformatf("t6_run%0d", r));
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
